tag_array_assoc: RTL and testbench
==================================

Name: tag_array_assoc

Overview:
- Parametrised set-associative tag store for the private L1 cache controller; successor to the single-way direct-mapped tag array.
- Holds NUM_WAYS ways of {valid, dirty, tag} per set, with a registered lookup that compares all ways in parallel and returns the hit way.
- Provides a second read-only snoop lookup port for coherence and a sequencer that flushes (invalidates) every set.

Parameters:
- ID, 0, cache controller index; used only in simulation messages.
- TAG_WIDTH, 20, stored tag width in bits.
- NUM_SETS, 16, sets per way; must be a power of 2 and at least 2.
- NUM_WAYS, 4, associativity; must be a power of 2 and at least 1.

Ports:
- clock  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high.
- lookup_valid  in  1  core lookup request.
- lookup_set  in  log2(NUM_SETS)  set index.
- lookup_tag  in  TAG_WIDTH  tag to compare.
- lookup_resp_valid  out  1  response valid, 1 cycle after an accepted request.
- lookup_hit  out  1  at least one valid way matched.
- lookup_hit_way  out  log2(NUM_WAYS)  lowest-index matching way.
- lookup_dirty  out  1  dirty bit of lookup_hit_way.
- lookup_tags  out  NUM_WAYS*TAG_WIDTH  all stored tags of the set, way 0 in the LSBs (victim writeback).
- lookup_valids  out  NUM_WAYS  valid bits of the set.
- multi_hit  out  1  more than one way matched (error flag).
- snoop_valid  in  1  snoop lookup request.
- snoop_set  in  log2(NUM_SETS)  snoop set index.
- snoop_tag  in  TAG_WIDTH  snoop tag.
- snoop_resp_valid  out  1  snoop response valid.
- snoop_hit  out  1  snoop matched a valid way.
- snoop_hit_way  out  log2(NUM_WAYS)  snoop matching way.
- write_en  in  1  update one way.
- write_set  in  log2(NUM_SETS)  set to update.
- write_way  in  log2(NUM_WAYS)  way to update.
- write_tag  in  TAG_WIDTH  new tag.
- write_valid  in  1  new valid bit.
- write_dirty  in  1  new dirty bit.
- flush_req  in  1  single-cycle pulse that starts a full invalidate.
- ready  out  1  high when lookups, snoops and writes are accepted.
- flush_done  out  1  single-cycle pulse when the flush completes.

Behaviour:
- Reset, asynchronous: all valid and dirty bits are 0; FSM enters IDLE; ready is 1; all response outputs, multi_hit and flush_done are 0. Tag contents are undefined; they are gated by the valid bits.
- Requests are accepted only while ready is 1. While ready is 0, lookup_valid, snoop_valid and write_en are ignored with no state change.
- Lookup timing: a lookup accepted in cycle N produces its response in cycle N+1.
  - The request fields are registered and the compare is done on registered RAM data.
  - Hit condition per way: valid and stored tag equal to lookup_tag.
  - lookup_hit_way is the priority-encoded lowest matching way; it is 0 and lookup_dirty is 0 when there is no hit.
- multi_hit is set in N+1 only when two or more ways match; lookup_hit is still 1 in that case.
- Response outputs hold their values while resp_valid is 0; no contract is given on their contents then.
- Snoop port: same timing and hit rules as the lookup port, fully independent. Lookup and snoop may target the same set in the same cycle.
- Write: takes effect at the clock edge.
  - A lookup or snoop to the same set in the same cycle returns the pre-write contents (read-first).
  - A lookup in the following cycle sees the new contents.
- Write with write_valid 0 invalidates the way; write_dirty is stored as given.
- FSM states:
  - IDLE: ready=1. A flush_req moves the FSM to FLUSH with the sweep counter at 0, and ready drops in the next cycle.
  - FLUSH: ready=0. Clears the valid and dirty bits of every way in set counter, one set per cycle, then increments the counter. The cycle that clears set NUM_SETS-1 moves to DONE.
  - DONE: flush_done=1 for one cycle, ready stays 0, then IDLE. A flush therefore takes NUM_SETS+1 cycles from flush_req to ready.
- Simultaneous events with flush_req in IDLE:
  - A write_en in the same cycle is performed, then swept.
  - A lookup in the same cycle is accepted and answers with pre-flush data.
- flush_req received in FLUSH or DONE is ignored.
- Sweep counter width is log2(NUM_SETS); it wraps to 0 on entering DONE.
- Reset asserted mid-flush: immediate return to IDLE with all bits cleared; no flush_done is produced.

Decomposition:
- Package tag_array_pkg holds:
  - the FSM state enum {IDLE, FLUSH, DONE};
  - the typedef tag_entry_t {valid, dirty, tag}, with the tag width taken from the module parameter through a parameterised struct macro or a localparam pattern;
  - a priority-encoder function.
- Sub-module tag_way_bank, one instance per way:
  - tag RAM with one write port and two read ports (lookup, snoop);
  - valid and dirty flop vectors with async reset and a sweep-clear input;
  - per-port registered compare output.

Test Plan:
- Reset, then lookup set 3 tag 0x12345 -> resp in cycle+1, hit=0, valids=0000, multi_hit=0.
- Write set 3 way 2 tag 0x12345 valid=1 dirty=1; lookup next cycle -> hit=1, hit_way=2, dirty=1; lookup tag 0x12346 -> hit=0.
- Write and lookup set 5 in the same cycle -> old contents (hit=0); same lookup one cycle later -> hit=1.
- Write tag 0xABCDE to ways 1 and 3 of set 7 -> lookup gives hit_way=1, multi_hit=1; a snoop in the same cycle gives snoop_hit_way=1.
- Fill all sets, pulse flush_req -> ready=0 for 17 cycles (NUM_SETS=16), flush_done at cycle 17, every lookup afterwards misses; a second flush_req mid-flush is ignored.
- Assert reset at sweep count 6 -> ready=1 next cycle, no flush_done, all valids=0.

Source files
------------

// File: rtl/tag_array_pkg.sv
// Shared types and helpers for the set-associative L1 tag store.
`ifndef TAG_ARRAY_PKG_SV
`define TAG_ARRAY_PKG_SV

// Tag entry layout; the tag width comes from the instantiating module's parameter.
`define TAG_ARRAY_ENTRY_T(W) struct packed { logic valid; logic dirty; logic [(W)-1:0] tag; }

package tag_array_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLUSH = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int PRIO_MAX = 64;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic int prio_enc(input logic [PRIO_MAX-1:0] vec);
        prio_enc = 0;
        for (int i = PRIO_MAX - 1; i >= 0; i--) begin
            if (vec[i]) prio_enc = i;
        end
    endfunction

endpackage

`endif

// File: rtl/tag_array_assoc_if.sv
// Request/response bundle between the L1 controller (master) and the tag store (slave).
interface tag_array_assoc_if #(
    parameter int TAG_WIDTH = 20,
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 4
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    logic                          lookup_valid;
    logic [SET_W-1:0]              lookup_set;
    logic [TAG_WIDTH-1:0]          lookup_tag;
    logic                          lookup_resp_valid;
    logic                          lookup_hit;
    logic [WAY_W-1:0]              lookup_hit_way;
    logic                          lookup_dirty;
    logic [NUM_WAYS*TAG_WIDTH-1:0] lookup_tags;
    logic [NUM_WAYS-1:0]           lookup_valids;
    logic                          multi_hit;

    logic                          snoop_valid;
    logic [SET_W-1:0]              snoop_set;
    logic [TAG_WIDTH-1:0]          snoop_tag;
    logic                          snoop_resp_valid;
    logic                          snoop_hit;
    logic [WAY_W-1:0]              snoop_hit_way;

    logic                          write_en;
    logic [SET_W-1:0]              write_set;
    logic [WAY_W-1:0]              write_way;
    logic [TAG_WIDTH-1:0]          write_tag;
    logic                          write_valid;
    logic                          write_dirty;

    logic                          flush_req;
    logic                          ready;
    logic                          flush_done;

    modport master (
        output lookup_valid, lookup_set, lookup_tag,
        input  lookup_resp_valid, lookup_hit, lookup_hit_way, lookup_dirty,
        input  lookup_tags, lookup_valids, multi_hit,
        output snoop_valid, snoop_set, snoop_tag,
        input  snoop_resp_valid, snoop_hit, snoop_hit_way,
        output write_en, write_set, write_way, write_tag, write_valid, write_dirty,
        output flush_req,
        input  ready, flush_done
    );

    modport slave (
        input  lookup_valid, lookup_set, lookup_tag,
        output lookup_resp_valid, lookup_hit, lookup_hit_way, lookup_dirty,
        output lookup_tags, lookup_valids, multi_hit,
        input  snoop_valid, snoop_set, snoop_tag,
        output snoop_resp_valid, snoop_hit, snoop_hit_way,
        input  write_en, write_set, write_way, write_tag, write_valid, write_dirty,
        input  flush_req,
        output ready, flush_done
    );
endinterface

// File: rtl/tag_way_bank.sv
// One way of the tag store: tag RAM, valid/dirty flops and registered per-port compares.
module tag_way_bank #(
    parameter int TAG_WIDTH = 20,
    parameter int NUM_SETS  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         wr_en_i,
    input  logic [$clog2(NUM_SETS)-1:0]  wr_set_i,
    input  logic [TAG_WIDTH-1:0]         wr_tag_i,
    input  logic                         wr_valid_i,
    input  logic                         wr_dirty_i,
    input  logic                         clr_en_i,
    input  logic [$clog2(NUM_SETS)-1:0]  clr_set_i,
    input  logic                         lk_en_i,
    input  logic [$clog2(NUM_SETS)-1:0]  lk_set_i,
    input  logic [TAG_WIDTH-1:0]         lk_tag_i,
    input  logic                         sn_en_i,
    input  logic [$clog2(NUM_SETS)-1:0]  sn_set_i,
    input  logic [TAG_WIDTH-1:0]         sn_tag_i,
    output logic                         lk_hit_o,
    output logic                         lk_valid_o,
    output logic                         lk_dirty_o,
    output logic [TAG_WIDTH-1:0]         lk_tag_o,
    output logic                         sn_hit_o
);
    typedef `TAG_ARRAY_ENTRY_T(TAG_WIDTH) tag_entry_t;

    logic [TAG_WIDTH-1:0] tag_mem [NUM_SETS];
    logic [NUM_SETS-1:0]  valid_q;
    logic [NUM_SETS-1:0]  dirty_q;
    tag_entry_t           lk_rd;
    tag_entry_t           lk_q;
    logic                 lk_hit_q;
    logic                 sn_hit_q;
    logic                 sn_match;

    // NOTE: the tag RAM has no reset; stale tags are harmless because valid_q gates every compare.
    always_ff @(posedge clock) begin
        if (wr_en_i) tag_mem[wr_set_i] <= wr_tag_i;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (clr_en_i) begin
            valid_q[clr_set_i] <= 1'b0;
            dirty_q[clr_set_i] <= 1'b0;
        end else if (wr_en_i) begin
            valid_q[wr_set_i] <= wr_valid_i;
            dirty_q[wr_set_i] <= wr_dirty_i;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    always_comb begin
        lk_rd       = '0;
        lk_rd.valid = valid_q[lk_set_i];
        lk_rd.dirty = dirty_q[lk_set_i];
        lk_rd.tag   = tag_mem[lk_set_i];
        sn_match    = valid_q[sn_set_i] && (tag_mem[sn_set_i] == sn_tag_i);
    end

    // Sampling current contents at the write edge gives read-first behaviour.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lk_q     <= '0;
            lk_hit_q <= 1'b0;
            sn_hit_q <= 1'b0;
        end else begin
            if (lk_en_i) begin
                lk_q     <= lk_rd;
                lk_hit_q <= lk_rd.valid && (lk_rd.tag == lk_tag_i);
            end
            if (sn_en_i) sn_hit_q <= sn_match;
        end
    end

    assign lk_hit_o   = lk_hit_q;
    assign lk_valid_o = lk_q.valid;
    assign lk_dirty_o = lk_q.dirty;
    assign lk_tag_o   = lk_q.tag;
    assign sn_hit_o   = sn_hit_q;
endmodule

// File: rtl/tag_array_assoc.sv
// Set-associative L1 tag store with a lookup port, a snoop port and a full-invalidate sequencer.
module tag_array_assoc
    import tag_array_pkg::*;
#(
    parameter int ID        = 0,
    parameter int TAG_WIDTH = 20,
    parameter int NUM_SETS  = 16,
    parameter int NUM_WAYS  = 4
) (
    input  logic             clock,
    input  logic             reset,
    tag_array_assoc_if.slave bus
);
    localparam int SET_W = $clog2(NUM_SETS);
    localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

    if (NUM_SETS < 2 || (NUM_SETS & (NUM_SETS - 1)) != 0) begin : g_bad_sets
        $error("tag_array_assoc[%0d]: NUM_SETS must be a power of 2 and >= 2", ID);
    end
    if (NUM_WAYS < 1 || NUM_WAYS > PRIO_MAX || (NUM_WAYS & (NUM_WAYS - 1)) != 0) begin : g_bad_ways
        $error("tag_array_assoc[%0d]: NUM_WAYS must be a power of 2 in 1..%0d", ID, PRIO_MAX);
    end

    state_e               state_q;
    logic [SET_W-1:0]     sweep_q;
    logic                 ready_q;
    logic                 flush_done_q;
    logic                 lk_resp_q;
    logic                 sn_resp_q;

    logic                 lk_accept;
    logic                 sn_accept;
    logic                 wr_accept;
    logic                 sweeping;

    logic [NUM_WAYS-1:0]  lk_hit_vec;
    logic [NUM_WAYS-1:0]  lk_valid_vec;
    logic [NUM_WAYS-1:0]  lk_dirty_vec;
    logic [NUM_WAYS-1:0]  sn_hit_vec;
    logic [TAG_WIDTH-1:0] lk_tag_arr [NUM_WAYS];
    logic [NUM_WAYS*TAG_WIDTH-1:0] lk_tag_flat;
    logic [WAY_W-1:0]     lk_way;
    logic [WAY_W-1:0]     sn_way;

    assign lk_accept = bus.lookup_valid && ready_q;
    assign sn_accept = bus.snoop_valid  && ready_q;
    assign wr_accept = bus.write_en     && ready_q;
    assign sweeping  = (state_q == FLUSH);

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        tag_way_bank #(
            .TAG_WIDTH (TAG_WIDTH),
            .NUM_SETS  (NUM_SETS)
        ) u_bank (
            .clock      (clock),
            .reset      (reset),
            .wr_en_i    (wr_accept && (bus.write_way == WAY_W'(w))),
            .wr_set_i   (bus.write_set),
            .wr_tag_i   (bus.write_tag),
            .wr_valid_i (bus.write_valid),
            .wr_dirty_i (bus.write_dirty),
            .clr_en_i   (sweeping),
            .clr_set_i  (sweep_q),
            .lk_en_i    (lk_accept),
            .lk_set_i   (bus.lookup_set),
            .lk_tag_i   (bus.lookup_tag),
            .sn_en_i    (sn_accept),
            .sn_set_i   (bus.snoop_set),
            .sn_tag_i   (bus.snoop_tag),
            .lk_hit_o   (lk_hit_vec[w]),
            .lk_valid_o (lk_valid_vec[w]),
            .lk_dirty_o (lk_dirty_vec[w]),
            .lk_tag_o   (lk_tag_arr[w]),
            .sn_hit_o   (sn_hit_vec[w])
        );
    end

    // Flush sequencer: one set cleared per FLUSH cycle, flush_done pulses in DONE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            sweep_q      <= '0;
            ready_q      <= 1'b1;
            flush_done_q <= 1'b0;
        end else begin
            flush_done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.flush_req) begin
                        state_q <= FLUSH;
                        sweep_q <= '0;
                        ready_q <= 1'b0;
                    end
                end
                FLUSH: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == SET_W'(NUM_SETS - 1)) begin
                        state_q      <= DONE;
                        flush_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lk_resp_q <= 1'b0;
            sn_resp_q <= 1'b0;
        end else begin
            lk_resp_q <= lk_accept;
            sn_resp_q <= sn_accept;
        end
    end

    always_comb begin
        lk_tag_flat = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            lk_tag_flat[w*TAG_WIDTH +: TAG_WIDTH] = lk_tag_arr[w];
        end
        lk_way = WAY_W'(prio_enc(PRIO_MAX'(lk_hit_vec)));
        sn_way = WAY_W'(prio_enc(PRIO_MAX'(sn_hit_vec)));
    end

    assign bus.ready             = ready_q;
    assign bus.flush_done        = flush_done_q;
    assign bus.lookup_resp_valid = lk_resp_q;
    assign bus.lookup_hit        = |lk_hit_vec;
    assign bus.lookup_hit_way    = lk_way;
    assign bus.lookup_dirty      = (|lk_hit_vec) && lk_dirty_vec[lk_way];
    assign bus.lookup_tags       = lk_tag_flat;
    assign bus.lookup_valids     = lk_valid_vec;
    assign bus.multi_hit         = (lk_hit_vec & (lk_hit_vec - 1'b1)) != '0;
    assign bus.snoop_resp_valid  = sn_resp_q;
    assign bus.snoop_hit         = |sn_hit_vec;
    assign bus.snoop_hit_way     = sn_way;
endmodule

// File: tb/tb_tag_array_assoc.sv
// Scoreboard bench for tag_array_assoc: directed stimulus queues expectations, a monitor checks responses.
module tb_tag_array_assoc;
    localparam int TW = 20;
    localparam int NS = 16;
    localparam int NW = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    tag_array_assoc_if #(.TAG_WIDTH(TW), .NUM_SETS(NS), .NUM_WAYS(NW)) bus ();

    tag_array_assoc #(
        .ID        (0),
        .TAG_WIDTH (TW),
        .NUM_SETS  (NS),
        .NUM_WAYS  (NW)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic          hit;
        logic [1:0]    way;
        logic          dirty;
        logic          multi;
        logic [NW-1:0] valids;
        logic [TW-1:0] tag;
    } lk_exp_t;

    typedef struct {
        logic       hit;
        logic [1:0] way;
    } sn_exp_t;

    lk_exp_t lk_sb [$];
    sn_exp_t sn_sb [$];
    lk_exp_t lk_e;
    sn_exp_t sn_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        bus.lookup_valid = 1'b0;
        bus.snoop_valid  = 1'b0;
        bus.write_en     = 1'b0;
        bus.flush_req    = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        clear_inputs();
    endtask

    task automatic lookup(input logic [3:0] s, input logic [TW-1:0] t, input logic hit,
                          input logic [1:0] way, input logic dirty, input logic multi,
                          input logic [NW-1:0] valids);
        bus.lookup_valid = 1'b1;
        bus.lookup_set   = s;
        bus.lookup_tag   = t;
        lk_sb.push_back('{hit: hit, way: way, dirty: dirty, multi: multi, valids: valids, tag: t});
    endtask

    task automatic snoop(input logic [3:0] s, input logic [TW-1:0] t, input logic hit,
                         input logic [1:0] way);
        bus.snoop_valid = 1'b1;
        bus.snoop_set   = s;
        bus.snoop_tag   = t;
        sn_sb.push_back('{hit: hit, way: way});
    endtask

    task automatic write(input logic [3:0] s, input logic [1:0] w, input logic [TW-1:0] t,
                         input logic v, input logic d);
        bus.write_en    = 1'b1;
        bus.write_set   = s;
        bus.write_way   = w;
        bus.write_tag   = t;
        bus.write_valid = v;
        bus.write_dirty = d;
    endtask

    // Response monitor, sampling on the falling edge.
    always @(negedge clock) begin
        if (bus.lookup_resp_valid) begin
            if (lk_sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL lookup_unexpected: actual=resp_valid required=no response at %0t", $time);
            end else begin
                lk_e = lk_sb.pop_front();
                check("lookup_hit",     32'(bus.lookup_hit),     32'(lk_e.hit));
                check("lookup_hit_way", 32'(bus.lookup_hit_way), 32'(lk_e.way));
                check("lookup_dirty",   32'(bus.lookup_dirty),   32'(lk_e.dirty));
                check("multi_hit",      32'(bus.multi_hit),      32'(lk_e.multi));
                check("lookup_valids",  32'(bus.lookup_valids),  32'(lk_e.valids));
                if (lk_e.hit)
                    check("lookup_tags_hitway", 32'(bus.lookup_tags[int'(lk_e.way)*TW +: TW]), 32'(lk_e.tag));
            end
        end
        if (bus.snoop_resp_valid) begin
            if (sn_sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL snoop_unexpected: actual=resp_valid required=no response at %0t", $time);
            end else begin
                sn_e = sn_sb.pop_front();
                check("snoop_hit",     32'(bus.snoop_hit),     32'(sn_e.hit));
                check("snoop_hit_way", 32'(bus.snoop_hit_way), 32'(sn_e.way));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=time limit reached required=self termination");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        clear_inputs();
        bus.lookup_set = '0; bus.lookup_tag = '0;
        bus.snoop_set  = '0; bus.snoop_tag  = '0;
        bus.write_set  = '0; bus.write_way  = '0; bus.write_tag = '0;
        bus.write_valid = 1'b0; bus.write_dirty = 1'b0;

        // Reset state
        repeat (2) @(negedge clock);
        check("reset_ready",      32'(bus.ready),             32'd1);
        check("reset_flush_done", 32'(bus.flush_done),        32'd0);
        check("reset_lk_resp",    32'(bus.lookup_resp_valid), 32'd0);
        check("reset_sn_resp",    32'(bus.snoop_resp_valid),  32'd0);
        check("reset_multi_hit",  32'(bus.multi_hit),         32'd0);
        @(posedge clock); #1; reset = 1'b0;

        // Cold miss, then write and hit
        lookup(4'd3, 20'h12345, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000); step();
        write(4'd3, 2'd2, 20'h12345, 1'b1, 1'b1); step();
        lookup(4'd3, 20'h12345, 1'b1, 2'd2, 1'b1, 1'b0, 4'b0100); step();
        lookup(4'd3, 20'h12346, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0100); step();

        // Read-first on same-cycle write
        write(4'd5, 2'd0, 20'h00555, 1'b1, 1'b0);
        lookup(4'd5, 20'h00555, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000); step();
        lookup(4'd5, 20'h00555, 1'b1, 2'd0, 1'b0, 1'b0, 4'b0001); step();

        // Duplicate tag in two ways: priority and multi_hit, snoop in parallel
        write(4'd7, 2'd1, 20'hABCDE, 1'b1, 1'b0); step();
        write(4'd7, 2'd3, 20'hABCDE, 1'b1, 1'b1); step();
        lookup(4'd7, 20'hABCDE, 1'b1, 2'd1, 1'b0, 1'b1, 4'b1010);
        snoop(4'd7, 20'hABCDE, 1'b1, 2'd1); step();
        lookup(4'd7, 20'h11111, 1'b0, 2'd0, 1'b0, 1'b0, 4'b1010);
        snoop(4'd7, 20'h11111, 1'b0, 2'd0); step();

        // Snoop read-first and hit on way 3
        write(4'd9, 2'd3, 20'h99999, 1'b1, 1'b0);
        snoop(4'd9, 20'h99999, 1'b0, 2'd0); step();
        snoop(4'd9, 20'h99999, 1'b1, 2'd3); step();

        // Invalidate through write_valid = 0
        write(4'd3, 2'd2, 20'h12345, 1'b0, 1'b0); step();
        lookup(4'd3, 20'h12345, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000); step();

        // Fill way 0 of every set
        for (int s = 0; s < NS; s++) begin
            write(4'(s), 2'd0, 20'(32'h100 + s), 1'b1, 1'b1); step();
        end

        // Flush with same-cycle write and lookup
        write(4'd10, 2'd1, 20'h77777, 1'b1, 1'b0);
        lookup(4'd7, 20'h00107, 1'b1, 2'd0, 1'b1, 1'b0, 4'b1011);
        bus.flush_req = 1'b1;
        step();
        for (int k = 1; k <= 18; k++) begin
            if (k == 5) bus.flush_req = 1'b1;
            if (k == 10) begin
                bus.lookup_valid = 1'b1; bus.lookup_set = 4'd2; bus.lookup_tag = 20'h22222;
                bus.snoop_valid  = 1'b1; bus.snoop_set  = 4'd2; bus.snoop_tag  = 20'h22222;
                write(4'd2, 2'd2, 20'h22222, 1'b1, 1'b0);
            end
            @(negedge clock);
            check($sformatf("flush_ready_c%0d", k), 32'(bus.ready),      32'(k == 18));
            check($sformatf("flush_done_c%0d", k),  32'(bus.flush_done), 32'(k == 17));
            @(posedge clock); #1; clear_inputs();
        end

        // Everything misses after the flush
        for (int s = 0; s < NS; s++) begin
            lookup(4'(s), 20'(32'h100 + s), 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000); step();
        end
        lookup(4'd10, 20'h77777, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000); step();
        lookup(4'd2, 20'h22222, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000);
        snoop(4'd9, 20'h99999, 1'b0, 2'd0); step();
        lookup(4'd7, 20'hABCDE, 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000); step();

        // Reset in the middle of a flush (sweep count 6)
        for (int s = 12; s < NS; s++) begin
            write(4'(s), 2'd1, 20'(32'h300 + s), 1'b1, 1'b0); step();
        end
        bus.flush_req = 1'b1;
        step();
        repeat (6) step();
        reset = 1'b1;
        @(negedge clock);
        check("midflush_rst_ready",      32'(bus.ready),      32'd1);
        check("midflush_rst_flush_done", 32'(bus.flush_done), 32'd0);
        @(posedge clock); #1; reset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            check("post_rst_no_flush_done", 32'(bus.flush_done), 32'd0);
            @(posedge clock); #1;
        end
        check("post_rst_ready", 32'(bus.ready), 32'd1);
        for (int s = 12; s < NS; s++) begin
            lookup(4'(s), 20'(32'h300 + s), 1'b0, 2'd0, 1'b0, 1'b0, 4'b0000); step();
        end

        repeat (3) step();
        check("lookup_sb_drained", 32'(lk_sb.size()), 32'd0);
        check("snoop_sb_drained",  32'(sn_sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
